// File: rtl/spi_pkg.sv
// Shared SPI definitions: responder FSM state encoding and SCK mode constants.
// Imported by the SPI responder and by other SPI front ends.
package spi_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_t;

  localparam logic SPI_CPOL_0 = 1'b0;
  localparam logic SPI_CPOL_1 = 1'b1;
  localparam logic SPI_CPHA_0 = 1'b0;
  localparam logic SPI_CPHA_1 = 1'b1;
  localparam int   SPI_BYTE_W = 8;

  // The leading SCK edge is the move away from the idle (CPOL) level.
  function automatic logic lead_edge(input logic cpol, input logic rise, input logic fall);
    return (cpol == SPI_CPOL_1) ? fall : rise;
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchroniser plus a history flop for one asynchronous pin.
// Provides the synced level and single-cycle rise/fall pulses.
module spi_pin_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic input_clk,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic sync_p0;
  logic sync_p1;
  logic hist_p2;

  always_ff @(posedge input_clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= RESET_VAL;
      sync_p1 <= RESET_VAL;
      hist_p2 <= RESET_VAL;
    end else begin
      sync_p0 <= pin;
      // metastability settles here; sync_p1 is the first trusted copy
      sync_p1 <= sync_p0;
      hist_p2 <= sync_p1;
    end
  end

  assign level = sync_p1;
  assign rise  = sync_p1 & ~hist_p2;
  assign fall  = ~sync_p1 & hist_p2;

endmodule

// File: rtl/spi_target.sv
// SPI responder: oversampled SPI pins, one-byte RX/TX holding registers,
// sticky overrun/underrun flags and an interrupt for the CPU bus.
module spi_target
  import spi_pkg::*;
#(
  parameter logic       POLARITY   = SPI_CPOL_0,
  parameter logic       PHASE      = SPI_CPHA_0,
  parameter logic [7:0] DEFAULT_TX = 8'hFF
) (
  input  logic       input_clk,
  input  logic       reset,
  input  logic       wr,
  input  logic [7:0] wdata,
  input  logic       rd,
  input  logic       clr_flags,
  output logic [7:0] rdata,
  output logic       rx_valid,
  output logic       tx_ready,
  output logic       overrun,
  output logic       underrun,
  output logic       selected,
  output logic       frame_end,
  output logic       irq,
  input  logic       spi_sck,
  input  logic       spi_ss,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe
);

  localparam int         DATA_W   = SPI_BYTE_W;
  localparam logic [2:0] LAST_BIT = 3'(DATA_W - 1);

  logic sck_level, sck_rise, sck_fall;
  logic ss_level, ss_rise, ss_fall;
  logic mosi_level, mosi_rise, mosi_fall;
  logic unused_sync;

  spi_pin_sync #(.RESET_VAL(POLARITY)) u_sync_sck (
    .input_clk (input_clk),
    .reset     (reset),
    .pin       (spi_sck),
    .level     (sck_level),
    .rise      (sck_rise),
    .fall      (sck_fall)
  );

  spi_pin_sync #(.RESET_VAL(1'b1)) u_sync_ss (
    .input_clk (input_clk),
    .reset     (reset),
    .pin       (spi_ss),
    .level     (ss_level),
    .rise      (ss_rise),
    .fall      (ss_fall)
  );

  spi_pin_sync #(.RESET_VAL(1'b0)) u_sync_mosi (
    .input_clk (input_clk),
    .reset     (reset),
    .pin       (spi_mosi),
    .level     (mosi_level),
    .rise      (mosi_rise),
    .fall      (mosi_fall)
  );

  assign unused_sync = ^{sck_level, ss_level, mosi_rise, mosi_fall};

  spi_state_t        state;
  logic [2:0]        bit_cnt;
  logic [DATA_W-1:0] rx_shift;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] tx_hold;
  logic              tx_full;

  logic              lead, trail, sample_edge, shift_edge;
  logic              enter, in_frame, byte_done, tx_load, tx_advance;
  logic [DATA_W-1:0] rx_next, tx_next;

  always_comb begin
    lead        = lead_edge(POLARITY, sck_rise, sck_fall);
    trail       = lead_edge(POLARITY, sck_fall, sck_rise);
    sample_edge = (PHASE == SPI_CPHA_1) ? trail : lead;
    shift_edge  = (PHASE == SPI_CPHA_1) ? lead : trail;

    enter       = (state == ST_IDLE) && ss_fall;
    in_frame    = (state == ST_ACTIVE) && !ss_rise;
    byte_done   = in_frame && sample_edge && (bit_cnt == LAST_BIT);

    // The next TX byte is fetched on the final shift edge (CPHA=0, counter
    // already wrapped) or on the final sample edge (CPHA=1).
    if (PHASE == SPI_CPHA_1) begin
      tx_load = enter || byte_done;
    end else begin
      tx_load = enter || (in_frame && shift_edge && (bit_cnt == 3'd0));
    end
    // With bit_cnt at 0 the shift edge is either the load (CPHA=0) or the
    // first leading edge that just presents the loaded MSB (CPHA=1).
    tx_advance  = in_frame && shift_edge && (bit_cnt != 3'd0);

    rx_next     = {rx_shift[DATA_W-2:0], mosi_level};
    tx_next     = tx_full ? tx_hold : DEFAULT_TX;
  end

  always_ff @(posedge input_clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      selected  <= 1'b0;
      frame_end <= 1'b0;
      bit_cnt   <= 3'd0;
      rx_shift  <= '0;
      tx_shift  <= '0;
      tx_hold   <= '0;
      tx_full   <= 1'b0;
      rdata     <= '0;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      underrun  <= 1'b0;
      spi_miso  <= 1'b1;
    end else begin
      frame_end <= 1'b0;

      // CPU-side clears first so same-cycle set events below take priority.
      if (rd) begin
        rx_valid <= 1'b0;
      end
      if (clr_flags) begin
        overrun  <= 1'b0;
        underrun <= 1'b0;
      end

      if (wr) begin
        tx_hold <= wdata;
        tx_full <= 1'b1;
      end else if (tx_load && tx_full) begin
        tx_full <= 1'b0;
      end

      if (tx_load) begin
        tx_shift <= tx_next;
        spi_miso <= tx_next[DATA_W-1];
        if (!tx_full) begin
          underrun <= 1'b1;
        end
      end else if (tx_advance) begin
        tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
        spi_miso <= tx_shift[DATA_W-2];
      end

      case (state)
        ST_IDLE: begin
          if (ss_fall) begin
            state    <= ST_ACTIVE;
            selected <= 1'b1;
            bit_cnt  <= 3'd0;
          end
        end
        ST_ACTIVE: begin
          if (ss_rise) begin
            state     <= ST_IDLE;
            selected  <= 1'b0;
            bit_cnt   <= 3'd0;
            frame_end <= 1'b1;
          end else if (sample_edge) begin
            rx_shift <= rx_next;
            bit_cnt  <= bit_cnt + 3'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase

      if (byte_done) begin
        rdata    <= rx_next;
        rx_valid <= 1'b1;
        if (rx_valid && !rd) begin
          overrun <= 1'b1;
        end
      end
    end
  end

  assign tx_ready    = ~tx_full;
  assign irq         = rx_valid | overrun;
  assign spi_miso_oe = selected;

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: one instance per SPI mode, each driven by a
// bit-banged host with SCK at input_clk/8.
`timescale 1ns/1ps
module tb_spi_target;

  localparam int H = 4;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] wr    = '0;
  logic [3:0] rd    = '0;
  logic [3:0] clr   = '0;
  logic [3:0] ss    = 4'b1111;
  logic [3:0] sck   = 4'b1100;
  logic [7:0] wdata = '0;
  logic       mosi  = 1'b0;

  logic [7:0] rdata [4];
  logic rx_valid [4], tx_ready [4], overrun [4], underrun [4];
  logic selected [4], frame_end [4], irq [4], miso [4], miso_oe [4];

  int errors = 0;
  int checks = 0;
  int fe_cnt [4] = '{0, 0, 0, 0};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_target #(
      .POLARITY   (1'((g / 2) % 2)),
      .PHASE      (1'(g % 2)),
      .DEFAULT_TX (8'hFF)
    ) u_dut (
      .input_clk   (clk),
      .reset       (reset),
      .wr          (wr[g]),
      .wdata       (wdata),
      .rd          (rd[g]),
      .clr_flags   (clr[g]),
      .rdata       (rdata[g]),
      .rx_valid    (rx_valid[g]),
      .tx_ready    (tx_ready[g]),
      .overrun     (overrun[g]),
      .underrun    (underrun[g]),
      .selected    (selected[g]),
      .frame_end   (frame_end[g]),
      .irq         (irq[g]),
      .spi_sck     (sck[g]),
      .spi_ss      (ss[g]),
      .spi_mosi    (mosi),
      .spi_miso    (miso[g]),
      .spi_miso_oe (miso_oe[g])
    );
  end

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (frame_end[k]) fe_cnt[k] <= fe_cnt[k] + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cpu_wr(input logic [1:0] m, input logic [7:0] d);
    wdata = d; wr[m] = 1'b1; tick(1); wr[m] = 1'b0; tick(1);
  endtask

  task automatic cpu_rd(input logic [1:0] m);
    rd[m] = 1'b1; tick(1); rd[m] = 1'b0; tick(1);
  endtask

  task automatic cpu_clr(input logic [1:0] m);
    clr[m] = 1'b1; tick(1); clr[m] = 1'b0; tick(1);
  endtask

  task automatic sel(input logic [1:0] m);
    ss[m] = 1'b0;
  endtask

  task automatic desel(input logic [1:0] m);
    tick(H); ss[m] = 1'b1; tick(H + 2);
  endtask

  // Half SCK period after a sample edge; optionally lands rd on the cycle
  // the DUT registers that edge (pin change + 3 clocks).
  task automatic settle(input logic [1:0] m, input bit do_rd);
    if (do_rd) begin
      tick(2); rd[m] = 1'b1; tick(1); rd[m] = 1'b0; tick(H - 3);
    end else begin
      tick(H);
    end
  endtask

  task automatic xfer(input logic [1:0] m, input logic [7:0] tx, input int nbits,
                      input bit rd_last, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i >= 8 - nbits; i--) begin
      if (m[0] == 1'b0) begin
        mosi = tx[3'(i)]; tick(H);
        rx[3'(i)] = miso[m];
        sck[m] = ~m[1];
        settle(m, rd_last && (i == 0));
        sck[m] = m[1];
      end else begin
        if (i == 7) tick(H);
        sck[m] = ~m[1]; mosi = tx[3'(i)]; tick(H);
        rx[3'(i)] = miso[m];
        sck[m] = m[1];
        settle(m, rd_last && (i == 0));
      end
    end
    if (m[0] == 1'b0) tick(H);
  endtask

  task automatic test_reset();
    reset = 1'b1; tick(3);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({rx_valid[k], tx_ready[k], overrun[k], underrun[k], selected[k], frame_end[k],
           miso[k], miso_oe[k], irq[k]} !== 9'b0_1_0_0_0_0_1_0_0) begin
        errors++;
        $display("FAIL reset_ctrl[%0d] got %b want 010000100", k,
                 {rx_valid[k], tx_ready[k], overrun[k], underrun[k], selected[k], frame_end[k],
                  miso[k], miso_oe[k], irq[k]});
      end
      checks++;
      if (rdata[k] !== 8'h00) begin errors++; $display("FAIL reset_rdata[%0d] got %h want 00", k, rdata[k]); end
    end
    reset = 1'b0; tick(4);
  endtask

  task automatic test_mode0_basic();
    logic [7:0] rx;
    cpu_wr(0, 8'hA5);
    checks++; if (tx_ready[0] !== 1'b0) begin errors++; $display("FAIL basic_tx_ready_full got %b want 0", tx_ready[0]); end
    sel(0); tick(4);
    checks++; if ({selected[0], miso_oe[0]} !== 2'b11) begin errors++; $display("FAIL basic_selected got %b want 11", {selected[0], miso_oe[0]}); end
    checks++; if (tx_ready[0] !== 1'b1) begin errors++; $display("FAIL basic_tx_ready_loaded got %b want 1", tx_ready[0]); end
    xfer(0, 8'h3C, 8, 1'b0, rx);
    desel(0);
    checks++; if (rx !== 8'hA5) begin errors++; $display("FAIL basic_miso got %h want a5", rx); end
    checks++; if (rdata[0] !== 8'h3C) begin errors++; $display("FAIL basic_rdata got %h want 3c", rdata[0]); end
    checks++; if ({rx_valid[0], irq[0], overrun[0]} !== 3'b110) begin errors++; $display("FAIL basic_valid_irq got %b want 110", {rx_valid[0], irq[0], overrun[0]}); end
    checks++; if (underrun[0] !== 1'b1) begin errors++; $display("FAIL basic_end_underrun got %b want 1", underrun[0]); end
    checks++; if ({selected[0], miso_oe[0]} !== 2'b00) begin errors++; $display("FAIL basic_deselect got %b want 00", {selected[0], miso_oe[0]}); end
    cpu_rd(0);
    checks++; if ({rx_valid[0], irq[0]} !== 2'b00) begin errors++; $display("FAIL basic_rd_clear got %b want 00", {rx_valid[0], irq[0]}); end
    cpu_clr(0);
    checks++; if (underrun[0] !== 1'b0) begin errors++; $display("FAIL basic_clr_underrun got %b want 0", underrun[0]); end
  endtask

  task automatic test_overrun();
    logic [7:0] r1, r2;
    sel(0);
    xfer(0, 8'h11, 8, 1'b0, r1);
    xfer(0, 8'h22, 8, 1'b0, r2);
    desel(0);
    checks++; if ({r1, r2} !== 16'hFFFF) begin errors++; $display("FAIL ovr_miso got %h want ffff", {r1, r2}); end
    checks++; if (rdata[0] !== 8'h22) begin errors++; $display("FAIL ovr_rdata got %h want 22", rdata[0]); end
    checks++; if ({overrun[0], underrun[0], irq[0]} !== 3'b111) begin errors++; $display("FAIL ovr_flags got %b want 111", {overrun[0], underrun[0], irq[0]}); end
    cpu_clr(0);
    checks++; if ({overrun[0], underrun[0], rx_valid[0]} !== 3'b001) begin errors++; $display("FAIL ovr_clr got %b want 001", {overrun[0], underrun[0], rx_valid[0]}); end
    cpu_rd(0);
    cpu_clr(0);
  endtask

  task automatic test_rd_at_completion();
    logic [7:0] rx;
    sel(0);
    xfer(0, 8'h33, 8, 1'b0, rx);
    xfer(0, 8'h44, 8, 1'b1, rx);
    desel(0);
    checks++; if ({rx_valid[0], overrun[0]} !== 2'b10) begin errors++; $display("FAIL rdcomp_valid_ovr got %b want 10", {rx_valid[0], overrun[0]}); end
    checks++; if (rdata[0] !== 8'h44) begin errors++; $display("FAIL rdcomp_rdata got %h want 44", rdata[0]); end
    cpu_clr(0);
  endtask

  task automatic test_abort();
    logic [7:0] rx;
    int base;
    base = fe_cnt[0];
    sel(0); tick(4);
    cpu_wr(0, 8'h77);
    xfer(0, 8'hFF, 5, 1'b0, rx);
    desel(0);
    checks++; if (fe_cnt[0] - base !== 1) begin errors++; $display("FAIL abort_frame_end got %0d want 1", fe_cnt[0] - base); end
    checks++; if ({rx_valid[0], overrun[0]} !== 2'b10) begin errors++; $display("FAIL abort_valid got %b want 10", {rx_valid[0], overrun[0]}); end
    checks++; if (rdata[0] !== 8'h44) begin errors++; $display("FAIL abort_rdata got %h want 44", rdata[0]); end
    checks++; if (tx_ready[0] !== 1'b0) begin errors++; $display("FAIL abort_tx_kept got %b want 0", tx_ready[0]); end
    cpu_rd(0);
    sel(0);
    xfer(0, 8'h5A, 8, 1'b0, rx);
    desel(0);
    checks++; if (rx !== 8'h77) begin errors++; $display("FAIL abort_next_miso got %h want 77", rx); end
    checks++; if ({rdata[0], rx_valid[0]} !== {8'h5A, 1'b1}) begin errors++; $display("FAIL abort_next_rdata got %h/%b want 5a/1", rdata[0], rx_valid[0]); end
    checks++; if (fe_cnt[0] - base !== 2) begin errors++; $display("FAIL abort_second_frame_end got %0d want 2", fe_cnt[0] - base); end
  endtask

  task automatic test_modes();
    logic [7:0] rx;
    logic [1:0] m;
    for (int k = 1; k < 4; k++) begin
      m = 2'(k);
      cpu_wr(m, 8'hC3);
      sel(m);
      xfer(m, 8'h96, 8, 1'b0, rx);
      desel(m);
      checks++; if (rx !== 8'hC3) begin errors++; $display("FAIL mode%0d_miso got %h want c3", k, rx); end
      checks++; if ({rdata[m], rx_valid[m]} !== {8'h96, 1'b1}) begin errors++; $display("FAIL mode%0d_rdata got %h/%b want 96/1", k, rdata[m], rx_valid[m]); end
    end
  endtask

  task automatic test_reset_midbyte();
    logic [7:0] rx;
    cpu_wr(0, 8'h3E);
    sel(0);
    xfer(0, 8'hF0, 4, 1'b0, rx);
    reset = 1'b1; ss[0] = 1'b1; tick(2);
    checks++;
    if ({rx_valid[0], tx_ready[0], overrun[0], underrun[0], selected[0], frame_end[0],
         miso[0], miso_oe[0], irq[0]} !== 9'b0_1_0_0_0_0_1_0_0) begin
      errors++;
      $display("FAIL midrst_ctrl got %b want 010000100",
               {rx_valid[0], tx_ready[0], overrun[0], underrun[0], selected[0], frame_end[0],
                miso[0], miso_oe[0], irq[0]});
    end
    checks++; if (rdata[0] !== 8'h00) begin errors++; $display("FAIL midrst_rdata got %h want 00", rdata[0]); end
    reset = 1'b0; tick(4);
    checks++; if ({selected[0], tx_ready[0]} !== 2'b01) begin errors++; $display("FAIL midrst_after got %b want 01", {selected[0], tx_ready[0]}); end
    sel(0);
    xfer(0, 8'h81, 8, 1'b0, rx);
    desel(0);
    checks++; if (rx !== 8'hFF) begin errors++; $display("FAIL midrst_miso got %h want ff", rx); end
    checks++; if ({rdata[0], rx_valid[0]} !== {8'h81, 1'b1}) begin errors++; $display("FAIL midrst_rdata_next got %h/%b want 81/1", rdata[0], rx_valid[0]); end
  endtask

  initial begin
    test_reset();
    test_mode0_basic();
    test_overrun();
    test_rd_at_completion();
    test_abort();
    test_modes();
    test_reset_midbyte();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
